// File: rtl/sbox_seq_ctrl.sv
// Sequencer for a shared masked S-box: issues NIB nibbles per pass and tracks results through a LAT-deep pipe.
// Define SBOX_RAND_STALL_EN to make each issue wait for rand_valid.
module sbox_seq_ctrl #(
   parameter int NIB = 16,
   parameter int LAT = 3,
   parameter int RW  = 36
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    clear,
   input  logic                    rand_valid,
   output logic                    busy,
   output logic                    done,
   output logic                    sbox_en,
   output logic [$clog2(NIB)-1:0]  nib_sel,
   output logic                    rand_ack,
   output logic                    rs_sel,
   output logic                    wr_en,
   output logic [$clog2(NIB)-1:0]  wr_idx
);

   localparam int IW = $clog2(NIB);
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   if (NIB < 2 || LAT < 2 || RW < 1) begin : g_bad_param
      $error("sbox_seq_ctrl: NIB and LAT must be >= 2, RW >= 1");
   end

   typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

   state_t                   state;
   logic [IW-1:0]            cnt;
   logic [LAT-1:0]           vld;
   logic [LAT-1:0][IW-1:0]   pidx;

   logic                     rand_ok;
   logic                     feeding;
   logic                     issue;
   logic [IW-1:0]            cur;

`ifdef SBOX_RAND_STALL_EN
   assign rand_ok = rand_valid;
`else
   logic unused_rand;
   assign unused_rand = rand_valid;
   assign rand_ok     = 1'b1;
`endif

   // Nibble 0 is issued on the very edge that accepts start, so a pass is NIB+LAT edges long.
   assign feeding = (state == FEED) || ((state == IDLE) && start);
   assign issue   = feeding && rand_ok && !clear;
   assign cur     = (state == FEED) ? cnt : '0;

   assign busy   = (state != IDLE);
   assign wr_en  = vld[LAT-1];
   assign wr_idx = pidx[LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         vld      <= '0;
         pidx     <= '0;
         sbox_en  <= 1'b0;
         rand_ack <= 1'b0;
         nib_sel  <= '0;
         rs_sel   <= 1'b0;
         done     <= 1'b0;
      end else if (clear) begin
         state    <= IDLE;
         cnt      <= '0;
         vld      <= '0;
         pidx     <= '0;
         sbox_en  <= 1'b0;
         rand_ack <= 1'b0;
         nib_sel  <= '0;
         rs_sel   <= 1'b0;
         done     <= 1'b0;
      end else begin
         // sbox_en is stage 0 of the valid pipe; the pipe shifts every cycle, bubbles included.
         vld      <= {vld[LAT-2:0], sbox_en};
         pidx     <= {pidx[LAT-2:0], nib_sel};
         sbox_en  <= issue;
         rand_ack <= issue;
         nib_sel  <= issue ? cur : '0;
         rs_sel   <= issue && (cur != '0);
         done     <= 1'b0;
         case (state)
            IDLE, FEED: begin
               if (feeding) begin
                  if (issue) begin
                     if (cur == LAST) begin
                        state <= DRAIN;
                        cnt   <= '0;
                     end else begin
                        state <= FEED;
                        cnt   <= cur + 1'b1;
                     end
                  end else begin
                     state <= FEED;
                     cnt   <= cur;
                  end
               end
            end
            DRAIN: begin
               if (!sbox_en && (vld[LAT-2:0] == '0)) begin
                  state <= IDLE;
                  done  <= wr_en;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
